// File: rtl/cpu_mips_pkg.sv
// Shared encodings, ALU operations and pipeline-register layouts for the cpu_mips core.
package cpu_mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [31:0] NOP = 32'h0000_0020;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st_data;
        logic [4:0]  wreg;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
    } idex_t;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] st_data;
        logic [4:0]  wreg;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
    } exmem_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wreg;
        logic        we;
    } memwb_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/cpu_mips_regfile.sv
// 32x32 register file: two read ports, one write port, write-through bypass, reset to index values.
module cpu_mips_regfile
    import cpu_mips_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= 32'(i);
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Same-cycle WB value is returned so ID sees it without an extra bubble.
    always_comb begin
        rd1_o = regs_q[ra1_i];
        if (ra1_i == 5'd0) begin
            rd1_o = '0;
        end else if (we_i && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
    end

    always_comb begin
        rd2_o = regs_q[ra2_i];
        if (ra2_i == 5'd0) begin
            rd2_o = '0;
        end else if (we_i && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/cpu_mips.sv
// Five-stage in-order MIPS32 subset core; branches resolve in ID, no forwarding or interlock.
module cpu_mips
    import cpu_mips_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] ii_miss_data,
    input  logic [127:0] id_miss_data,
    output logic [31:0]  oi_addr,
    output logic [31:0]  od_addr,
    output logic [31:0]  od_write_data,
    output logic         od_SIG_write
);

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    logic [31:0] fetch_word, rs_data, rt_data, imm_ext, br_target, alu_y, load_word;
    logic        taken;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [10:0] fn;

    cpu_mips_regfile u_regfile (
        .clk   (clk),
        .rstn  (rstn),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_data),
        .rd2_o (rt_data),
        .we_i  (memwb_q.we),
        .wa_i  (memwb_q.wreg),
        .wd_i  (memwb_q.res)
    );

    assign fetch_word = ii_miss_data[{pc_q[3:2], 5'd0} +: 32];
    assign opcode     = ifid_q.instr[31:26];
    assign rs         = ifid_q.instr[25:21];
    assign rt         = ifid_q.instr[20:16];
    assign rd         = ifid_q.instr[15:11];
    assign fn         = ifid_q.instr[10:0];
    assign imm_ext    = sext16(ifid_q.instr[15:0]);

    // R-type requires a zero shamt field; anything else falls through as a nop.
    always_comb begin
        idex_d    = '0;
        taken     = 1'b0;
        br_target = '0;
        case (opcode)
            OP_RTYPE: begin
                idex_d.a    = rs_data;
                idex_d.b    = rt_data;
                idex_d.wreg = rd;
                idex_d.we   = 1'b1;
                case (fn)
                    {5'd0, FN_ADD}: idex_d.op = ALU_ADD;
                    {5'd0, FN_SUB}: idex_d.op = ALU_SUB;
                    {5'd0, FN_AND}: idex_d.op = ALU_AND;
                    {5'd0, FN_OR}:  idex_d.op = ALU_OR;
                    {5'd0, FN_SLT}: idex_d.op = ALU_SLT;
                    default:        idex_d.we = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW: begin
                idex_d.a      = rs_data;
                idex_d.b      = imm_ext;
                idex_d.wreg   = rt;
                idex_d.we     = 1'b1;
                idex_d.mem_rd = (opcode == OP_LW);
            end
            OP_SW: begin
                idex_d.a       = rs_data;
                idex_d.b       = imm_ext;
                idex_d.st_data = rt_data;
                idex_d.mem_wr  = 1'b1;
            end
            OP_BEQ: begin
                taken     = (rs_data == rt_data);
                br_target = ifid_q.pc4 + {imm_ext[29:0], 2'b00};
            end
            OP_J: begin
                taken     = 1'b1;
                br_target = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d         = taken ? br_target : pc_q + 32'd4;
        ifid_d.pc4   = pc_q + 32'd4;
        ifid_d.instr = taken ? NOP : fetch_word;
    end

    always_comb begin
        case (idex_q.op)
            ALU_ADD: alu_y = idex_q.a + idex_q.b;
            ALU_SUB: alu_y = idex_q.a - idex_q.b;
            ALU_AND: alu_y = idex_q.a & idex_q.b;
            ALU_OR:  alu_y = idex_q.a | idex_q.b;
            ALU_SLT: alu_y = {31'd0, ($signed(idex_q.a) < $signed(idex_q.b))};
            default: alu_y = '0;
        endcase
        exmem_d.res     = alu_y;
        exmem_d.st_data = idex_q.st_data;
        exmem_d.wreg    = idex_q.wreg;
        exmem_d.we      = idex_q.we;
        exmem_d.mem_rd  = idex_q.mem_rd;
        exmem_d.mem_wr  = idex_q.mem_wr;
    end

    assign load_word = id_miss_data[{exmem_q.res[3:2], 5'd0} +: 32];

    always_comb begin
        memwb_d.res  = exmem_q.mem_rd ? load_word : exmem_q.res;
        memwb_d.wreg = exmem_q.wreg;
        memwb_d.we   = exmem_q.we;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q    <= '0;
            ifid_q  <= '{pc4: '0, instr: NOP};
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign oi_addr       = pc_q;
    assign od_addr       = exmem_q.res;
    assign od_write_data = exmem_q.st_data;
    assign od_SIG_write  = exmem_q.mem_wr;

endmodule

// File: tb/tb_cpu_mips.sv
// Directed programs checked every cycle against an instruction-level model of fetch order and MEM-stage traffic.
module tb_cpu_mips;

    localparam int MAXC = 64;
    localparam logic [31:0] NOPW = 32'h0000_0020;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [127:0] ii_miss_data;
    logic [127:0] id_miss_data;
    logic [31:0]  oi_addr, od_addr, od_write_data;
    logic         od_SIG_write;

    cpu_mips dut (
        .clk           (clk),
        .rstn          (rstn),
        .ii_miss_data  (ii_miss_data),
        .id_miss_data  (id_miss_data),
        .oi_addr       (oi_addr),
        .od_addr       (od_addr),
        .od_write_data (od_write_data),
        .od_SIG_write  (od_SIG_write)
    );

    always #5 clk = ~clk;

    logic [31:0] prog [64];
    logic [31:0] exp_pc   [MAXC];
    logic [31:0] exp_addr [MAXC];
    logic [31:0] exp_data [MAXC];
    bit          exp_sw   [MAXC];
    bit          exp_lw   [MAXC];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e = 0;
    bit active = 1'b0;

    always_comb begin
        ii_miss_data = {prog[{oi_addr[7:4], 2'd3}], prog[{oi_addr[7:4], 2'd2}],
                        prog[{oi_addr[7:4], 2'd1}], prog[{oi_addr[7:4], 2'd0}]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Instruction-level model: sequential execution, one fetch per cycle, one bubble after a taken control transfer.
    task automatic model_run();
        logic [31:0] r [32];
        logic [31:0] pc, ins, imm, tgt, a;
        logic [4:0]  rs, rt, rd;
        bit          squash;
        for (int i = 0; i < 32; i++) r[i] = 32'(i);
        pc = 0; tgt = 0; squash = 0;
        for (int c = 0; c < MAXC; c++) begin
            exp_pc[c] = pc; exp_sw[c] = 0; exp_lw[c] = 0; exp_addr[c] = 0; exp_data[c] = 0;
            if (squash) begin
                squash = 0;
                pc = tgt;
            end else begin
                ins = prog[pc[7:2]];
                rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
                imm = {{16{ins[15]}}, ins[15:0]};
                a = r[rs] + imm;
                case (ins[31:26])
                    6'h00: case (ins[5:0])
                        6'h20: r[rd] = r[rs] + r[rt];
                        6'h22: r[rd] = r[rs] - r[rt];
                        6'h24: r[rd] = r[rs] & r[rt];
                        6'h25: r[rd] = r[rs] | r[rt];
                        6'h2a: r[rd] = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
                        default: ;
                    endcase
                    6'h08: r[rt] = a;
                    6'h23: begin
                        exp_lw[c] = 1; exp_addr[c] = a;
                        r[rt] = id_miss_data[{a[3:2], 5'd0} +: 32];
                    end
                    6'h2b: begin
                        exp_sw[c] = 1; exp_addr[c] = a; exp_data[c] = r[rt];
                    end
                    6'h04: if (r[rs] == r[rt]) begin
                        squash = 1; tgt = pc + 4 + (imm << 2);
                    end
                    6'h02: begin
                        squash = 1; tgt = {pc[31:28] + 4'd0, ins[25:0], 2'b00};
                        tgt[31:28] = (pc + 4) >> 28;
                    end
                    default: ;
                endcase
                r[0] = 0;
                pc = pc + 4;
            end
        end
    endtask

    always @(negedge clk) begin
        if (active && cyc < MAXC) begin
            chk($sformatf("oi_addr@%0d", cyc), oi_addr, exp_pc[cyc]);
            if (cyc >= 3 && exp_sw[cyc-3]) begin
                chk($sformatf("sig_write@%0d", cyc), {31'd0, od_SIG_write}, 32'd1);
                chk($sformatf("sw_addr@%0d", cyc), od_addr, exp_addr[cyc-3]);
                chk($sformatf("sw_data@%0d", cyc), od_write_data, exp_data[cyc-3]);
            end else begin
                chk($sformatf("sig_write@%0d", cyc), {31'd0, od_SIG_write}, 32'd0);
                if (cyc >= 3 && exp_lw[cyc-3])
                    chk($sformatf("lw_addr@%0d", cyc), od_addr, exp_addr[cyc-3]);
            end
            cyc++;
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = NOPW;
    endtask

    task automatic start_run();
        model_run();
        @(posedge clk);
        #2 rstn = 1'b1;
        e = 0; cyc = 0; active = 1'b1;
        #1;
    endtask

    task automatic to_edge(input int n);
        while (e < n) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic end_run(input int n);
        to_edge(n);
        active = 1'b0;
        rstn = 1'b0;
    endtask

    task automatic chk_od(input string name, input logic sig, input logic [31:0] addr, input logic [31:0] data);
        chk({name, "_sig"}, {31'd0, od_SIG_write}, {31'd0, sig});
        chk({name, "_addr"}, od_addr, addr);
        chk({name, "_data"}, od_write_data, data);
    endtask

    initial begin
        id_miss_data = '0;
        clear_prog();
        #1 rstn = 1'b0;
        #1;
        chk("reset_oi_addr", oi_addr, 32'd0);
        chk_od("reset", 1'b0, 32'd0, 32'd0);

        // sw $2,8($3) at PC 0, then mid-run reset
        clear_prog();
        prog[0] = 32'hAC62_0008; prog[3] = 32'h0021_0820;
        start_run();
        to_edge(3);
        chk_od("sw_first", 1'b1, 32'h0000_000B, 32'd2);
        #2 active = 1'b0; rstn = 1'b0;
        #1;
        chk("midreset_oi_addr", oi_addr, 32'd0);
        chk_od("midreset", 1'b0, 32'd0, 32'd0);
        start_run();
        chk("restart_oi_addr", oi_addr, 32'd0);
        to_edge(3);
        chk_od("sw_restart", 1'b1, 32'h0000_000B, 32'd2);
        end_run(30);

        // add chain through bypass, result stored by sw $1
        clear_prog();
        prog[0] = 32'h0043_0820; prog[3] = 32'h0021_0820; prog[6] = 32'hAC01_0000;
        start_run();
        to_edge(9);
        chk_od("add_chain", 1'b1, 32'd0, 32'd10);
        end_run(30);

        // slt/sub/and/or/addi mix
        clear_prog();
        prog[0]  = 32'h0043_082a; prog[1]  = 32'h0042_202a; prog[2]  = 32'h0002_3022;
        prog[3]  = 32'h00EE_4024; prog[4]  = 32'h00AA_4825; prog[5]  = 32'h200A_FFFF;
        prog[6]  = 32'h00C0_382A;
        prog[9]  = 32'hAC01_0000; prog[10] = 32'hAC04_0004; prog[11] = 32'hAC06_0008;
        prog[12] = 32'hAC08_000C; prog[13] = 32'hAC09_0010; prog[14] = 32'hAC0A_0014;
        prog[15] = 32'hAC07_0018;
        start_run();
        to_edge(12); chk("slt_lt", od_write_data, 32'd1);
        to_edge(13); chk("slt_eq", od_write_data, 32'd0);
        to_edge(14); chk("sub_neg", od_write_data, 32'hFFFF_FFFE);
        to_edge(15); chk("and", od_write_data, 32'd6);
        to_edge(16); chk("or", od_write_data, 32'd15);
        to_edge(17); chk("addi_neg", od_write_data, 32'hFFFF_FFFF);
        to_edge(18); chk("slt_signed", od_write_data, 32'd1);
        end_run(30);

        // lw from uniform line
        clear_prog();
        id_miss_data = {4{32'hDEAD_BEEF}};
        prog[0] = 32'h8C61_0008; prog[3] = 32'hAC01_0000;
        start_run();
        to_edge(3);
        chk("lw_sig", {31'd0, od_SIG_write}, 32'd0);
        chk("lw_addr", od_addr, 32'h0000_000B);
        to_edge(6);
        chk_od("lw_store", 1'b1, 32'd0, 32'hDEAD_BEEF);
        end_run(20);

        // lw word selection within the line
        clear_prog();
        id_miss_data = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
        prog[0] = 32'h8C61_0008; prog[1] = 32'h8C02_0004;
        prog[3] = 32'hAC01_0000; prog[4] = 32'hAC02_0004;
        start_run();
        to_edge(6); chk("lw_word2", od_write_data, 32'hC2C2_C2C2);
        to_edge(7); chk("lw_word1", od_write_data, 32'hB1B1_B1B1);
        end_run(20);

        // beq taken, j, beq not taken
        clear_prog();
        prog[0] = 32'h1000_0001; prog[1] = 32'h0021_0820; prog[3] = 32'h0800_0006;
        prog[4] = 32'h2001_0063; prog[5] = 32'h2001_004D; prog[6] = 32'hAC01_0000;
        prog[7] = 32'h1043_0005; prog[8] = 32'hAC02_0004;
        start_run();
        chk("br_pc0", oi_addr, 32'd0);
        to_edge(1); chk("br_pc1", oi_addr, 32'd4);
        to_edge(2); chk("br_pc2", oi_addr, 32'd8);
        to_edge(3); chk("br_pc3", oi_addr, 32'd12);
        to_edge(5); chk("j_pc", oi_addr, 32'd24);
        to_edge(8); chk_od("squash_store", 1'b1, 32'd0, 32'd1);
        end_run(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
